skew_feeder: RTL and testbench
==============================

# skew_feeder

Tile-vector feeder that sits directly upstream of the systolic array's input skew registers. It buffers up to DEPTH packed N-lane vectors, written one at a time by the loader. On a start command it streams them one per cycle with an enable strobe, then appends N-1 zero vectors so the triangular skew chain and the array edge fully drain. It supports downstream back-pressure and signals completion with a one-cycle done pulse.

## Interface
- DATA_WIDTH, 16, bits per lane element
- N, 16, lanes per vector (array edge size); N >= 1
- DEPTH, 16, vectors held in the tile buffer
- ADDR_WIDTH, 4, log2(DEPTH)
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write strobe into tile buffer
- wr_addr  input  ADDR_WIDTH  buffer entry to write
- wr_data  input  DATA_WIDTH*N  packed vector, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- start  input  1  begin streaming; sampled only in IDLE
- len  input  ADDR_WIDTH+1  number of vectors to stream, legal 1..DEPTH
- hold  input  1  downstream stall request
- packed_dout  output  DATA_WIDTH*N  vector to skew registers, same lane packing
- skew_en  output  1  enable for the skew registers; high on every advancing cycle
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse on an illegal start

## Operation
- Tile buffer: DEPTH x (DATA_WIDTH*N). It is not reset, and contents persist across operations.
- A write is committed when wr_en=1 and busy=0, except in the cycle an accepted start is sampled. Writes while busy or on an accepted-start cycle are dropped.
- States:
  - IDLE → STREAM on start with 1 <= len <= DEPTH. len is latched and the index is cleared.
  - IDLE, on start with len=0 or len>DEPTH: pulse err and stay in IDLE.
  - STREAM: present buffer[idx]. On a non-held cycle idx++. After len vectors, go to FLUSH, or to DONE if N=1.
  - FLUSH: present all-zero vectors with skew_en=1 for N-1 non-held cycles, then go to DONE.
  - DONE: done=1 for one cycle, busy=1, skew_en=0, then go to IDLE.
- start while busy is ignored and does not set err.
- hold:
  - In STREAM/FLUSH, hold=1 in cycle t makes cycle t+1 a stall cycle.
  - A stall cycle has skew_en=0, packed_dout unchanged, and no counter advance.
  - Progress resumes the cycle after hold is sampled low.
  - hold is ignored in IDLE and DONE.
- All outputs are registered.
- packed_dout is 0 in IDLE and DONE.
- skew_en is 0 outside STREAM/FLUSH.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, idx = 0, and all outputs 0 (packed_dout, skew_en, busy, done, err) immediately, without waiting for clk.
- Reset mid-operation aborts the operation. No done pulse is issued. After release, the block is in IDLE and accepts a new start.
- Accepted start sampled at edge T, no hold:
  - busy=1 and skew_en=1 with buffer[0] from T+1.
  - buffer[k] is presented at T+1+k.
  - Zero vectors are presented at T+len+1 .. T+len+N-1.
  - done=1 at T+len+N.
  - busy=0 from T+len+N+1.
- Each stall cycle delays every subsequent event by exactly one cycle.
- Earliest back-to-back start: sampled in the first IDLE cycle after done, i.e. a gap of one IDLE cycle.
- An illegal start at edge T gives err=1 at T+1 only, with busy staying 0.
- Total enabled cycles per operation = len + N - 1 exactly, independent of hold.

## Test plan
- **Reset values:** assert rst_n low mid-clock → all outputs read 0 before the next edge. Release, then hold start=0 → outputs stay 0.
- **Basic stream (N=4, DATA_WIDTH=16):**
  - Stimulus: write entry k with lane i = 16'h(k*16+i) for k=0..3, then start with len=4 at T.
  - Required: entries 0..3 at T+1..T+4 with skew_en=1; zeros at T+5..T+7 with skew_en=1; done at T+8; busy low at T+9.
- **Hold:** assert hold for the two edges after T+2 → skew_en=0 with packed_dout frozen at entry 1 for two cycles; done moves to T+10; enabled-cycle count stays 7.
- **Illegal and ignored commands:**
  - start with len=0 → err pulse one cycle later, busy stays 0.
  - start with len=17 (DEPTH=16) → same err pulse, busy stays 0.
  - start while busy → no effect.
  - wr_en while busy → buffer unchanged, verified by a second stream.
- **Reset mid-FLUSH:** pull rst_n low during a flush cycle → outputs 0 immediately and no done pulse. A new start with len=1 then gives entry 0, three zero vectors, and done at T+5.
- **Edge config N=1, len=DEPTH=16:** 16 enabled cycles, no flush, done at T+17. Back-to-back start in the IDLE cycle after done is accepted.

Source files
------------

// File: rtl/skew_feeder.sv
// Tile-vector feeder for the systolic array input skew chain: buffers DEPTH
// packed N-lane vectors, streams len of them on start, then appends N-1 zero vectors.
module skew_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH*N-1:0] wr_data,
    input  logic                    start,
    input  logic [ADDR_WIDTH:0]     len,
    input  logic                    hold,
    output logic [DATA_WIDTH*N-1:0] packed_dout,
    output logic                    skew_en,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int VW = DATA_WIDTH * N;
    localparam int FW = (N > 2) ? $clog2(N - 1) : 1;
    localparam logic [FW-1:0]       FLUSH_LAST = FW'((N > 1) ? (N - 2) : 0);
    localparam logic [ADDR_WIDTH:0] DEPTH_L    = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    logic [VW-1:0]         mem_r [DEPTH];
    state_t                state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0] idx_r, idx_nxt_s;
    logic [ADDR_WIDTH-1:0] len_m1_r, len_m1_nxt_s;
    logic [FW-1:0]         fcnt_r, fcnt_nxt_s;
    logic [VW-1:0]         dout_r, dout_nxt_s;
    logic                  skew_en_r, skew_en_nxt_s;
    logic                  busy_r, busy_nxt_s;
    logic                  done_r, done_nxt_s;
    logic                  err_r, err_nxt_s;
    logic                  err_pend_r, err_pend_nxt_s;
    logic                  start_acc_s;
    logic                  len_ok_s;
    logic                  wr_commit_s;
    logic [VW-1:0]         rd_data_s;

    assign len_ok_s    = (len != {(ADDR_WIDTH + 1){1'b0}}) && (len <= DEPTH_L);
    assign rd_data_s   = mem_r[idx_r];
    // busy_r is the registered busy output, so writes follow exactly what the loader sees
    assign wr_commit_s = wr_en && !busy_r && !start_acc_s;

    assign packed_dout = dout_r;
    assign skew_en     = skew_en_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;

    // Tile buffer storage, deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_commit_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Next-state and next-output logic; outputs for an edge are decided by the state before it
    always_comb begin
        state_nxt_s    = state_r;
        idx_nxt_s      = idx_r;
        len_m1_nxt_s   = len_m1_r;
        fcnt_nxt_s     = fcnt_r;
        dout_nxt_s     = dout_r;
        skew_en_nxt_s  = 1'b0;
        busy_nxt_s     = 1'b1;
        done_nxt_s     = 1'b0;
        err_nxt_s      = err_pend_r;
        err_pend_nxt_s = 1'b0;
        start_acc_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                dout_nxt_s = {VW{1'b0}};
                busy_nxt_s = 1'b0;
                idx_nxt_s  = {ADDR_WIDTH{1'b0}};
                fcnt_nxt_s = {FW{1'b0}};
                if (start) begin
                    if (len_ok_s) begin
                        start_acc_s  = 1'b1;
                        state_nxt_s  = ST_STREAM;
                        len_m1_nxt_s = len[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                    end else begin
                        err_pend_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (hold) begin
                    dout_nxt_s = dout_r;
                end else begin
                    dout_nxt_s    = rd_data_s;
                    skew_en_nxt_s = 1'b1;
                    if (idx_r == len_m1_r) begin
                        idx_nxt_s   = {ADDR_WIDTH{1'b0}};
                        state_nxt_s = (N == 1) ? ST_DONE : ST_FLUSH;
                    end else begin
                        idx_nxt_s = idx_r + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (hold) begin
                    dout_nxt_s = dout_r;
                end else begin
                    dout_nxt_s    = {VW{1'b0}};
                    skew_en_nxt_s = 1'b1;
                    if (fcnt_r == FLUSH_LAST) begin
                        fcnt_nxt_s  = {FW{1'b0}};
                        state_nxt_s = ST_DONE;
                    end else begin
                        fcnt_nxt_s = fcnt_r + FW'(1);
                    end
                end
            end
            ST_DONE: begin
                dout_nxt_s  = {VW{1'b0}};
                done_nxt_s  = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                dout_nxt_s  = {VW{1'b0}};
                busy_nxt_s  = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            idx_r      <= {ADDR_WIDTH{1'b0}};
            len_m1_r   <= {ADDR_WIDTH{1'b0}};
            fcnt_r     <= {FW{1'b0}};
            dout_r     <= {VW{1'b0}};
            skew_en_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_pend_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            len_m1_r   <= len_m1_nxt_s;
            fcnt_r     <= fcnt_nxt_s;
            dout_r     <= dout_nxt_s;
            skew_en_r  <= skew_en_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
            err_pend_r <= err_pend_nxt_s;
        end
    end

endmodule

// File: tb/tb_skew_feeder.sv
// Scoreboard bench for skew_feeder: an N=4 instance for streaming/hold/error/reset
// cases and an N=1 instance for the full-depth, back-to-back case.
module tb_skew_feeder;

    typedef struct {
        int          cyc;
        int          kind;   // 0 vector, 1 done (data = enabled count), 2 err
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        q4[$];
    exp_t        q1[$];

    logic        rst4, wr4, start4, hold4, en4, busy4, done4, err4;
    logic [3:0]  waddr4;
    logic [4:0]  len4;
    logic [63:0] wdata4, dout4;

    logic        rst1, wr1, start1, hold1, en1, busy1, done1, err1;
    logic [3:0]  waddr1;
    logic [4:0]  len1;
    logic [15:0] wdata1, dout1;

    int          en_cnt4 = 0;
    int          en_cnt1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    skew_feeder #(.DATA_WIDTH(16), .N(4), .DEPTH(16), .ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst4), .wr_en(wr4), .wr_addr(waddr4), .wr_data(wdata4),
        .start(start4), .len(len4), .hold(hold4), .packed_dout(dout4),
        .skew_en(en4), .busy(busy4), .done(done4), .err(err4)
    );

    skew_feeder #(.DATA_WIDTH(16), .N(1), .DEPTH(16), .ADDR_WIDTH(4)) dut1 (
        .clk(clk), .rst_n(rst1), .wr_en(wr1), .wr_addr(waddr1), .wr_data(wdata1),
        .start(start1), .len(len1), .hold(hold1), .packed_dout(dout1),
        .skew_en(en1), .busy(busy1), .done(done1), .err(err1)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [63:0] vec4(input int k);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(k * 16 + i);
        return v;
    endfunction

    // Expected responses of one operation; stalls are inserted before enabled cycle stall_at
    task automatic push_op(input int which, input int t, input int ln, input int n,
                           input int stall_at, input int stalls);
        exp_t e;
        for (int k = 0; k < ln + n - 1; k++) begin
            e.cyc  = t + 1 + k + ((k >= stall_at) ? stalls : 0);
            e.kind = 0;
            if (which == 1) e.data = (k < ln) ? 64'(16'hA000 + 16'(k)) : 64'd0;
            else            e.data = (k < ln) ? vec4(k) : 64'd0;
            if (which == 1) q1.push_back(e); else q4.push_back(e);
        end
        e.cyc  = t + ln + n + stalls;
        e.kind = 1;
        e.data = 64'(ln + n - 1);
        if (which == 1) q1.push_back(e); else q4.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input int which);
        for (int i = 0; i < 60; i++) begin
            if (which == 1 ? (q1.size() == 0) : (q4.size() == 0)) break;
            @(negedge clk);
        end
        chk(which == 1 ? "drain1" : "drain4", 64'(which == 1 ? q1.size() : q4.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_start4(input int ln, output int t);
        start4 = 1'b1;
        len4   = 5'(ln);
        t      = cyc + 1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    // Monitor for the N=4 instance
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (rst4 === 1'b1) begin
            if (en4) en_cnt4 = en_cnt4 + 1;
            if (en4 || done4 || err4) begin
                kind = en4 ? 0 : (done4 ? 1 : 2);
                if (q4.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out4: kind %0d dout %h at cycle %0d", kind, dout4, cyc);
                end else begin
                    e = q4.pop_front();
                    chk("kind4", 64'(kind), 64'(e.kind));
                    chk("cyc4", 64'(cyc), 64'(e.cyc));
                    chk("data4", en4 ? dout4 : (done4 ? 64'(en_cnt4) : 64'd0), e.data);
                end
                if (done4) en_cnt4 = 0;
            end
        end else begin
            en_cnt4 = 0;
        end
    end

    // Monitor for the N=1 instance
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (rst1 === 1'b1) begin
            if (en1) en_cnt1 = en_cnt1 + 1;
            if (en1 || done1 || err1) begin
                kind = en1 ? 0 : (done1 ? 1 : 2);
                if (q1.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out1: kind %0d dout %h at cycle %0d", kind, dout1, cyc);
                end else begin
                    e = q1.pop_front();
                    chk("kind1", 64'(kind), 64'(e.kind));
                    chk("cyc1", 64'(cyc), 64'(e.cyc));
                    chk("data1", en1 ? 64'(dout1) : (done1 ? 64'(en_cnt1) : 64'd0), e.data);
                end
                if (done1) en_cnt1 = 0;
            end
        end else begin
            en_cnt1 = 0;
        end
    end

    initial begin
        int   t;
        exp_t e;
        rst4 = 1'b0; wr4 = 1'b0; start4 = 1'b0; hold4 = 1'b0; waddr4 = 4'd0; wdata4 = 64'd0; len4 = 5'd0;
        rst1 = 1'b0; wr1 = 1'b0; start1 = 1'b0; hold1 = 1'b0; waddr1 = 4'd0; wdata1 = 16'd0; len1 = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout4, 64'd0);
        chk("rst_en", {63'd0, en4}, 64'd0);
        chk("rst_busy", {63'd0, busy4}, 64'd0);
        rst4 = 1'b1; rst1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_dout", dout4, 64'd0);
        chk("idle_flags", {60'd0, en4, busy4, done4, err4}, 64'd0);
        chk("idle_busy1", {63'd0, busy1}, 64'd0);

        // Load both tile buffers
        for (int k = 0; k < 16; k++) begin
            wr4 = (k < 4); waddr4 = 4'(k); wdata4 = vec4(k);
            wr1 = 1'b1;    waddr1 = 4'(k); wdata1 = 16'hA000 + 16'(k);
            @(negedge clk);
        end
        wr4 = 1'b0; wr1 = 1'b0;

        // Basic stream
        do_start4(4, t);
        push_op(4, t, 4, 4, 99, 0);
        wait_cyc(t + 1); chk("busy_t1", {63'd0, busy4}, 64'd1);
        wait_cyc(t + 8); chk("busy_done", {63'd0, busy4}, 64'd1);
        wait_cyc(t + 9); chk("busy_end", {63'd0, busy4}, 64'd0);
        drain(4);

        // Two-cycle hold after entry 1
        do_start4(4, t);
        push_op(4, t, 4, 4, 2, 2);
        wait_cyc(t + 2); hold4 = 1'b1;
        wait_cyc(t + 3);
        chk("stall1_en", {63'd0, en4}, 64'd0);
        chk("stall1_dout", dout4, vec4(1));
        wait_cyc(t + 4);
        chk("stall2_en", {63'd0, en4}, 64'd0);
        chk("stall2_dout", dout4, vec4(1));
        hold4 = 1'b0;
        wait_cyc(t + 10); chk("hold_done", {63'd0, done4}, 64'd1);
        drain(4);

        // Illegal lengths
        for (int j = 0; j < 2; j++) begin
            do_start4(j == 0 ? 0 : 17, t);
            e.cyc = t + 1; e.kind = 2; e.data = 64'd0;
            q4.push_back(e);
            wait_cyc(t + 1); chk("err_busy", {63'd0, busy4}, 64'd0);
            drain(4);
        end

        // Start and write while busy are both ignored
        do_start4(4, t);
        push_op(4, t, 4, 4, 99, 0);
        wait_cyc(t + 2);
        wr4 = 1'b1; waddr4 = 4'd3; wdata4 = {64{1'b1}}; start4 = 1'b1; len4 = 5'd2;
        @(negedge clk);
        wr4 = 1'b0; start4 = 1'b0;
        drain(4);
        do_start4(4, t);
        push_op(4, t, 4, 4, 99, 0);
        drain(4);

        // Asynchronous reset during a flush cycle
        do_start4(4, t);
        push_op(4, t, 4, 4, 99, 0);
        wait_cyc(t + 5);
        #1 rst4 = 1'b0;
        #1;
        chk("arst_dout", dout4, 64'd0);
        chk("arst_flags", {60'd0, en4, busy4, done4, err4}, 64'd0);
        chk("arst_pending", 64'(q4.size()), 64'd3);
        q4.delete();
        repeat (2) @(negedge clk);
        rst4 = 1'b1;
        repeat (12) @(negedge clk);
        do_start4(1, t);
        push_op(4, t, 1, 4, 99, 0);
        drain(4);

        // N=1, full depth, then back-to-back start in the first idle cycle
        start1 = 1'b1; len1 = 5'd16; t = cyc + 1;
        @(negedge clk);
        start1 = 1'b0;
        push_op(1, t, 16, 1, 99, 0);
        wait_cyc(t + 17);
        chk("n1_done", {63'd0, done1}, 64'd1);
        start1 = 1'b1; len1 = 5'd2;
        push_op(1, t + 18, 2, 1, 99, 0);
        @(negedge clk);
        start1 = 1'b0;
        chk("n1_gap_busy", {63'd0, busy1}, 64'd0);
        wait_cyc(t + 19); chk("n1_b2b_busy", {63'd0, busy1}, 64'd1);
        drain(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
